// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: load-use, MEM redirect, DMEM wait with timeout.
// Optional perf counters under HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT   = 16,
  parameter int REDIR_BUBBLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             mem_redirect_i,
  input  logic             mem_access_i,
  input  logic             dmem_ready_i,
  input  logic             err_clr_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             idex_hold_o,
  output logic             exmem_flush_o,
  output logic             exmem_hold_o,
  output logic             memwb_bubble_o,
  output logic [1:0]       state_o,
`ifdef HAZ_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
`endif
  output logic             mem_err_o
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    WAIT  = 2'b01,
    REDIR = 2'b10,
    ILL   = 2'b11
  } state_t;

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(MEM_TIMEOUT - 1);
  localparam logic [WCW-1:0] W_ONE  = WCW'(1);
  localparam logic [2:0]     BUBS   = 3'(REDIR_BUBBLES);

  state_t         state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [2:0]     bcnt_q, bcnt_d;
  logic           err_set;
  logic           redir_acc;
  logic           lu_hit;
  logic           mem_wait;

  assign lu_hit = ex_memread_i && (ex_rd_i != 5'd0) &&
                  ((ex_rd_i == id_rs_i) ||
                   (id_uses_rt_i && (ex_rd_i == id_rt_i)));
  assign mem_wait = mem_access_i && !dmem_ready_i;
  assign state_o  = state_q;

  always_comb begin
    state_d        = state_q;
    wcnt_d         = wcnt_q;
    bcnt_d         = bcnt_q;
    err_set        = 1'b0;
    redir_acc      = 1'b0;
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_flush_o   = 1'b0;
    idex_hold_o    = 1'b0;
    exmem_flush_o  = 1'b0;
    exmem_hold_o   = 1'b0;
    memwb_bubble_o = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_redirect_i) begin
          ifid_flush_o  = 1'b1;
          idex_flush_o  = 1'b1;
          exmem_flush_o = 1'b1;
          redir_acc     = 1'b1;
          bcnt_d        = BUBS;
          state_d       = (REDIR_BUBBLES > 0) ? REDIR : RUN;
        end else if (mem_wait) begin
          pc_write_o     = 1'b0;
          ifid_write_o   = 1'b0;
          idex_hold_o    = 1'b1;
          exmem_hold_o   = 1'b1;
          memwb_bubble_o = 1'b1;
          wcnt_d         = W_ONE;
          state_d        = WAIT;
        end else if (lu_hit) begin
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          idex_flush_o = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_ready_i) begin
          wcnt_d  = '0;
          state_d = RUN;
        end else if (wcnt_q >= W_LAST) begin
          // Forced release: the stuck access is dropped and flagged
          err_set = 1'b1;
          wcnt_d  = '0;
          state_d = RUN;
        end else begin
          pc_write_o     = 1'b0;
          ifid_write_o   = 1'b0;
          idex_hold_o    = 1'b1;
          exmem_hold_o   = 1'b1;
          memwb_bubble_o = 1'b1;
          wcnt_d         = wcnt_q + W_ONE;
        end
      end
      REDIR: begin
        ifid_flush_o = 1'b1;
        if (mem_redirect_i) begin
          idex_flush_o  = 1'b1;
          exmem_flush_o = 1'b1;
          redir_acc     = 1'b1;
          bcnt_d        = BUBS;
        end else if (bcnt_q <= 3'd1) begin
          bcnt_d  = '0;
          state_d = RUN;
        end else begin
          bcnt_d = bcnt_q - 3'd1;
        end
      end
      default: begin
        wcnt_d  = '0;
        bcnt_d  = '0;
        state_d = RUN;
      end
    endcase
    if (!rst_n) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_flush_o   = 1'b1;
      idex_hold_o    = 1'b0;
      exmem_flush_o  = 1'b1;
      exmem_hold_o   = 1'b0;
      memwb_bubble_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      bcnt_q    <= '0;
      mem_err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      if (err_set)
        mem_err_o <= 1'b1;
      else if (err_clr_i)
        mem_err_o <= 1'b0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!pc_write_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (redir_acc && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = redir_acc;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, REDIR_BUBBLES=2).
// Output byte: {pcw, ifw, iff, idf, idh, exf, exh, bub}.
module tb_pipe_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs_i = '0, id_rt_i = '0, ex_rd_i = '0;
  logic       id_uses_rt_i = 0, ex_memread_i = 0, mem_redirect_i = 0;
  logic       mem_access_i = 0, dmem_ready_i = 0, err_clr_i = 0;
  logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o;
  logic       idex_hold_o, exmem_flush_o, exmem_hold_o, memwb_bubble_o;
  logic [1:0] state_o;
  logic       mem_err_o;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_o, flush_cnt_o;
`endif

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(4), .REDIR_BUBBLES(2), .CNT_W(16)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_uses_rt_i(id_uses_rt_i), .ex_memread_i(ex_memread_i),
    .ex_rd_i(ex_rd_i), .mem_redirect_i(mem_redirect_i),
    .mem_access_i(mem_access_i), .dmem_ready_i(dmem_ready_i),
    .err_clr_i(err_clr_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o),
    .idex_hold_o(idex_hold_o), .exmem_flush_o(exmem_flush_o),
    .exmem_hold_o(exmem_hold_o), .memwb_bubble_o(memwb_bubble_o),
    .state_o(state_o),
`ifdef HAZ_PERF_CNT_EN
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
`endif
    .mem_err_o(mem_err_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [7:0] O_RUN = 8'b1100_0000;
  localparam logic [7:0] O_RST = 8'b0011_0101;
  localparam logic [7:0] O_LU  = 8'b0001_0000;
  localparam logic [7:0] O_RED = 8'b1111_0100;
  localparam logic [7:0] O_BUB = 8'b1110_0000;
  localparam logic [7:0] O_FRZ = 8'b0000_1011;

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic       uses_rt, memread, redir, access, ready, clr;
    logic [7:0] out;
    logic [1:0] st;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    input logic [4:0] rs, rt, rd,
    input logic uses_rt, memread, redir, access, ready, clr,
    input logic [7:0] out, input logic [1:0] st, input logic err);
    vec_t v;
    v.rs = rs; v.rt = rt; v.rd = rd;
    v.uses_rt = uses_rt; v.memread = memread; v.redir = redir;
    v.access = access; v.ready = ready; v.clr = clr;
    v.out = out; v.st = st; v.err = err;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
            idex_hold_o, exmem_flush_o, exmem_hold_o, memwb_bubble_o};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs_i = v.rs; id_rt_i = v.rt; ex_rd_i = v.rd;
    id_uses_rt_i = v.uses_rt; ex_memread_i = v.memread;
    mem_redirect_i = v.redir; mem_access_i = v.access;
    dmem_ready_i = v.ready; err_clr_i = v.clr;
  endtask

  initial begin
    // rs rt rd  ur mr rd ac rdy clr   out    st     err
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 2'd0, 0));
    vecs.push_back(mk(8, 0, 8, 0, 1, 0, 0, 0, 0, O_LU,  2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, O_RUN, 2'd0, 0));
    vecs.push_back(mk(3, 8, 8, 0, 1, 0, 0, 0, 0, O_RUN, 2'd0, 0));
    vecs.push_back(mk(3, 8, 8, 1, 1, 0, 0, 0, 0, O_LU,  2'd0, 0));
    vecs.push_back(mk(8, 0, 8, 0, 0, 0, 0, 0, 0, O_RUN, 2'd0, 0));
    vecs.push_back(mk(8, 0, 8, 0, 1, 1, 1, 0, 0, O_RED, 2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUB, 2'd2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUB, 2'd2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, O_RED, 2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUB, 2'd2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, O_RED, 2'd2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUB, 2'd2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_BUB, 2'd2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 2'd0, 0));
    vecs.push_back(mk(8, 0, 8, 0, 1, 0, 1, 0, 0, O_FRZ, 2'd0, 0));
    vecs.push_back(mk(8, 0, 8, 0, 1, 0, 1, 0, 0, O_FRZ, 2'd1, 0));
    vecs.push_back(mk(8, 0, 8, 0, 1, 0, 1, 0, 0, O_FRZ, 2'd1, 0));
    vecs.push_back(mk(8, 0, 8, 0, 1, 0, 1, 1, 0, O_RUN, 2'd1, 0));
    vecs.push_back(mk(8, 0, 8, 0, 1, 0, 0, 0, 0, O_LU,  2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, O_RUN, 2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ, 2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ, 2'd1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ, 2'd1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_RUN, 2'd1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 2'd0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_RUN, 2'd0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ, 2'd0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ, 2'd1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ, 2'd1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, O_RUN, 2'd1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 2'd0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_RUN, 2'd0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 2'd0, 0));

    #2;
    chk("rst_out", 16'(outs()), 16'(O_RST));
    chk("rst_state", 16'(state_o), 16'd0);
    chk("rst_err", 16'(mem_err_o), 16'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt_o, 16'd0);
    chk("rst_flush_cnt", flush_cnt_o, 16'd0);
`endif
    @(negedge clk_i);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_out", i), 16'(outs()), 16'(vecs[i].out));
      chk($sformatf("v%0d_state", i), 16'(state_o), 16'(vecs[i].st));
      chk($sformatf("v%0d_err", i), 16'(mem_err_o), 16'(vecs[i].err));
      @(negedge clk_i);
    end

`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt", stall_cnt_o, 16'd12);
    chk("flush_cnt", flush_cnt_o, 16'd3);
`endif

    // Asynchronous reset while frozen in WAIT
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ, 2'd0, 0));
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    chk("pre_rst_state", 16'(state_o), 16'd1);
    chk("pre_rst_out", 16'(outs()), 16'(O_FRZ));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 16'(state_o), 16'd0);
    chk("mid_rst_out", 16'(outs()), 16'(O_RST));
`ifdef HAZ_PERF_CNT_EN
    chk("mid_rst_stall_cnt", stall_cnt_o, 16'd0);
    chk("mid_rst_flush_cnt", flush_cnt_o, 16'd0);
`endif
    @(negedge clk_i);
    rst_n = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 2'd0, 0));
    #1;
    chk("post_rst_out", 16'(outs()), 16'(O_RUN));
    @(negedge clk_i);
    #1;
    chk("post_rst_state", 16'(state_o), 16'd0);
    chk("post_rst_err", 16'(mem_err_o), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
